// File: rtl/regfile_wb_arbiter.sv
// Write-back controller for the 8x8 register file.
// Arbitrates NREQ write requesters onto the single write port and keeps a
// per-register busy scoreboard for RAW/WAW hazard detection at decode.
// Optional build macro WB_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins)
// instead of round-robin; scoreboard and output stage are unchanged.
module regfile_wb_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned NREG = 8,
  parameter int unsigned DW   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [3*NREQ-1:0]    req_rd,
  input  logic [DW*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rf_we,
  output logic [2:0]           rf_rd,
  output logic [DW-1:0]        rf_data,
  input  logic                 rsv_valid,
  input  logic [2:0]           rsv_rd,
  output logic                 rsv_ready,
  input  logic [2:0]           chk_rs1,
  input  logic [2:0]           chk_rs2,
  output logic                 hazard,
  output logic [NREG-1:0]      busy_mask,
  output logic                 err_unreserved
);

  localparam int unsigned IDXW = 3;
  localparam int unsigned PTRW = (NREQ > 2) ? 2 : 1;

  logic [PTRW-1:0] rr_ptr;
  logic [NREQ-1:0] grant_c;
  logic [PTRW-1:0] gidx_c;
  logic            acc_c;

  logic            rf_we_q, rf_we_d;
  logic [IDXW-1:0] rf_rd_q, rf_rd_d;
  logic [DW-1:0]   rf_data_q, rf_data_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            err_q, err_d;

`ifdef WB_ARB_FIXED_PRIO_EN
  // Fixed priority: search always starts at requester 0.
  assign rr_ptr = '0;
`else
  logic [PTRW-1:0] rr_ptr_q, rr_ptr_d;

  // Round-robin pointer moves just past the requester that was accepted.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (acc_c) begin
      rr_ptr_d = (gidx_c == PTRW'(NREQ - 1)) ? '0 : gidx_c + 1'b1;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

  assign rr_ptr = rr_ptr_q;
`endif

  // Grant the first valid requester searching upward from rr_ptr, wrapping.
  always_comb begin
    grant_c = '0;
    gidx_c  = '0;
    acc_c   = 1'b0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (!acc_c && req_valid[(int'(rr_ptr) + k) % int'(NREQ)]) begin
        acc_c  = 1'b1;
        gidx_c = PTRW'((int'(rr_ptr) + k) % int'(NREQ));
      end
    end
    if (acc_c) grant_c[gidx_c] = 1'b1;
  end

  assign req_ready = grant_c;
  assign rsv_ready = ~busy_q[rsv_rd];
  assign hazard    = busy_q[chk_rs1] | busy_q[chk_rs2];

  // Capture the accepted write; update scoreboard with set winning over clear.
  always_comb begin
    rf_we_d   = acc_c;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    if (acc_c) begin
      rf_rd_d   = req_rd[int'(gidx_c) * int'(IDXW) +: IDXW];
      rf_data_d = req_data[int'(gidx_c) * int'(DW) +: DW];
    end
    busy_d = busy_q;
    if (rf_we_q) busy_d[rf_rd_q] = 1'b0;
    if (rsv_valid && rsv_ready) busy_d[rsv_rd] = 1'b1;
    err_d = err_q | (rf_we_q & ~busy_q[rf_rd_q]);
  end

  // Output stage, scoreboard and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q   <= 1'b0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
      busy_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      rf_we_q   <= rf_we_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign rf_we          = rf_we_q;
  assign rf_rd          = rf_rd_q;
  assign rf_data        = rf_data_q;
  assign busy_mask      = busy_q;
  assign err_unreserved = err_q;

endmodule
